lr_dot_seq: RTL and testbench
=============================

Name: lr_dot_seq

Overview:
- Sequences a single shared saturating Q-format multiply/add datapath to compute one linear-regression prediction per frame: y = bias + sum over i of w[i]*x[i], for i = 0..N_FEAT-1.
- Weights and bias sit in an internal register file, loaded through a config write port.
- Features arrive as a valid/ready stream. Results leave as a valid/ready stream carrying sticky saturation and framing-error flags.
- Instantiates fp_mul and fp_add internally, one of each, combinationally chained.

Parameters:
WIDTH, 32, signed fixed-point word width
FRACTION, 16, fractional bits (Q16.16 default)
N_FEAT, 8, features per frame (>=1)
ADDR_W, 4, config address width; must satisfy 2**ADDR_W > N_FEAT

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  run enable; 0 forces IDLE
cfg_we  in  1  config write strobe
cfg_addr  in  ADDR_W  0..N_FEAT-1 selects w[i]; N_FEAT selects bias; others ignored
cfg_wdata  in  WIDTH  signed write data
x_valid  in  1  feature beat valid
x_ready  out  1  feature beat accepted when x_valid&x_ready
x_data  in  WIDTH  signed feature
x_last  in  1  marks final beat of frame
y_valid  out  1  result valid
y_ready  in  1  result consumed when y_valid&y_ready
y_data  out  WIDTH  signed prediction
y_sat  out  1  any saturation occurred during this frame
y_err  out  1  x_last placement error in this frame
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; x_ready=0, y_valid=0, y_data=0, y_sat=0, y_err=0, busy=0; idx=0; acc=0; all weights and bias cleared to 0.
- States: IDLE, ACC, OUT.
- IDLE: cfg writes honoured only here; cfg_we in any other state is ignored.
- IDLE -> ACC when en=1. On that edge: acc<=bias, idx<=0, sat_st<=0, err_st<=0.
- ACC: x_ready=1. On each accepted beat:
  - acc <= fp_add(acc, fp_mul(w[idx], x_data)).
  - sat_st |= mul.sat | add.sat.
  - idx increments.
- Error tracking in ACC:
  - If x_last=1 while idx != N_FEAT-1: set err_st and end the frame on that beat.
  - If x_last=0 while idx == N_FEAT-1: set err_st; the frame still ends on that beat.
- Frame end: ACC -> OUT on the edge that accepts the ending beat. y_data, y_sat and y_err are registered from the post-update values of acc, sat_st and err_st.
- OUT: x_ready=0; y_valid=1; y_data/y_sat/y_err held stable until y_ready.
  - On handshake: y_valid<=0 next cycle; acc<=bias, idx<=0, sticky flags cleared.
  - Next state is ACC if en=1, else IDLE.
- Throughput: 1 feature per cycle in ACC. Latency from ending-beat acceptance to y_valid is 1 cycle. There is at least 1 idle cycle (OUT) between frames.
- en=0 in ACC or OUT: abort at the next edge to IDLE. Partial result discarded, y_valid<=0, no output produced.
- Arithmetic: product and sum use fp_mul/fp_add semantics (round-to-nearest, saturate to signed WIDTH). Accumulation is sequential, so saturation persists: once acc clamps, later terms operate on the clamped value.
- x_valid=0 in ACC: no state change; the stall is indefinite.
- y_ready=0 in OUT: x_ready stays 0, so backpressure propagates upstream.
- cfg_addr > N_FEAT: write dropped silently.

Test Plan:
1. Reset, load w[i]=0x00010000 (1.0) for all i and bias=0x00008000 (0.5); en=1; stream x=1.0..8.0 (x_last on beat 8) -> y_data=0x00248000 (36.5), y_sat=0, y_err=0, y_valid exactly 1 cycle after beat 8.
2. w[0]=0x7FFF0000, x[0]=0x00020000, rest 0 -> y_data=0x7FFFFFFF, y_sat=1.
3. x_last asserted on beat 3 -> frame ends after 3 beats, y_err=1, y_data=bias+w0x0+w1x1+w2x2; next frame, correctly framed, has y_err=0.
4. Hold y_ready=0 for 5 cycles in OUT -> y_data stable, x_ready=0 throughout; on release, next frame starts with acc=bias.
5. Drop en after beat 4 -> IDLE next cycle, no y_valid. A cfg write to w[0] during ACC is ignored (verify via next frame); the same write in IDLE takes effect.
6. Assert rst_n=0 mid-OUT, asynchronously -> y_valid, busy and x_ready drop immediately; weights read back as 0 (next frame result = 0).

Source files
------------

// File: rtl/lr_dot_seq.sv
// Linear-regression predictor: one shared saturating Q-format multiply/add datapath
// accumulates bias + sum(w[i]*x[i]) over a streamed feature frame.

module fp_mul #(
   parameter int WIDTH    = 32,
   parameter int FRACTION = 16
) (
   input  logic signed [WIDTH-1:0] a_i,
   input  logic signed [WIDTH-1:0] b_i,
   output logic signed [WIDTH-1:0] p_o,
   output logic                    sat_o
);
   localparam logic signed [2*WIDTH:0] HALF =
      {{(2*WIDTH+1-FRACTION){1'b0}}, 1'b1, {(FRACTION-1){1'b0}}};
   localparam logic signed [2*WIDTH:0] MAXV = {{(WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [2*WIDTH:0] MINV = {{(WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};

   logic signed [2*WIDTH-1:0] aExt, bExt, prod;
   logic signed [2*WIDTH:0]   rnd, shifted;

   // Round half up at the fractional boundary, then clamp to the signed word range.
   always_comb begin
      aExt    = {{WIDTH{a_i[WIDTH-1]}}, a_i};
      bExt    = {{WIDTH{b_i[WIDTH-1]}}, b_i};
      prod    = aExt * bExt;
      rnd     = {prod[2*WIDTH-1], prod} + HALF;
      shifted = rnd >>> FRACTION;
      sat_o   = (shifted > MAXV) || (shifted < MINV);
      if (shifted > MAXV)      p_o = {1'b0, {(WIDTH-1){1'b1}}};
      else if (shifted < MINV) p_o = {1'b1, {(WIDTH-1){1'b0}}};
      else                     p_o = shifted[WIDTH-1:0];
   end
endmodule

module fp_add #(
   parameter int WIDTH = 32
) (
   input  logic signed [WIDTH-1:0] a_i,
   input  logic signed [WIDTH-1:0] b_i,
   output logic signed [WIDTH-1:0] s_o,
   output logic                    sat_o
);
   logic signed [WIDTH:0] sumW;

   always_comb begin
      sumW  = {a_i[WIDTH-1], a_i} + {b_i[WIDTH-1], b_i};
      sat_o = sumW[WIDTH] ^ sumW[WIDTH-1];
      if (!sat_o)          s_o = sumW[WIDTH-1:0];
      else if (sumW[WIDTH]) s_o = {1'b1, {(WIDTH-1){1'b0}}};
      else                  s_o = {1'b0, {(WIDTH-1){1'b1}}};
   end
endmodule

module lr_dot_seq #(
   parameter int WIDTH    = 32,
   parameter int FRACTION = 16,
   parameter int N_FEAT   = 8,
   parameter int ADDR_W   = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    cfg_we,
   input  logic [ADDR_W-1:0]       cfg_addr,
   input  logic signed [WIDTH-1:0] cfg_wdata,
   input  logic                    x_valid,
   output logic                    x_ready,
   input  logic signed [WIDTH-1:0] x_data,
   input  logic                    x_last,
   output logic                    y_valid,
   input  logic                    y_ready,
   output logic signed [WIDTH-1:0] y_data,
   output logic                    y_sat,
   output logic                    y_err,
   output logic                    busy
);
   typedef enum logic [1:0] {IDLE, ACC, OUT} state_e;

   state_e state_q, state_d;

   logic signed [WIDTH-1:0] w_q [N_FEAT];
   logic signed [WIDTH-1:0] bias_q;
   logic signed [WIDTH-1:0] acc_q, acc_d;
   logic [ADDR_W-1:0]       idx_q, idx_d;
   logic                    satSt_q, satSt_d, errSt_q, errSt_d;
   logic signed [WIDTH-1:0] yData_q, yData_d;
   logic                    ySat_q, ySat_d, yErr_q, yErr_d;

   logic signed [WIDTH-1:0] wSel, prod, sum;
   logic                    mulSat, addSat;
   logic                    beatFire, lastIdx, frameEnd, startFrame;

   always_comb begin
      wSel = '0;
      for (int i = 0; i < N_FEAT; i++)
         if (idx_q == ADDR_W'(i)) wSel = w_q[i];
   end

   fp_mul #(.WIDTH(WIDTH), .FRACTION(FRACTION)) u_mul (
      .a_i(wSel), .b_i(x_data), .p_o(prod), .sat_o(mulSat)
   );

   fp_add #(.WIDTH(WIDTH)) u_add (
      .a_i(acc_q), .b_i(prod), .s_o(sum), .sat_o(addSat)
   );

   assign beatFire   = (state_q == ACC) && en && x_valid;
   assign lastIdx    = (idx_q == ADDR_W'(N_FEAT-1));
   assign frameEnd   = beatFire && (x_last || lastIdx);
   assign startFrame = en && ((state_q == IDLE) || ((state_q == OUT) && y_ready));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Dropping en aborts any frame in flight; otherwise OUT waits for the consumer.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (en) state_d = ACC;
         ACC:     if (!en) state_d = IDLE;
                  else if (frameEnd) state_d = OUT;
         OUT:     if (!en) state_d = IDLE;
                  else if (y_ready) state_d = ACC;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      x_ready = (state_q == ACC);
      y_valid = (state_q == OUT);
      busy    = (state_q != IDLE);
      y_data  = yData_q;
      y_sat   = ySat_q;
      y_err   = yErr_q;
   end

   // The result registers capture post-update values so the last beat counts.
   always_comb begin
      acc_d   = acc_q;
      idx_d   = idx_q;
      satSt_d = satSt_q;
      errSt_d = errSt_q;
      yData_d = yData_q;
      ySat_d  = ySat_q;
      yErr_d  = yErr_q;
      if (startFrame) begin
         acc_d   = bias_q;
         idx_d   = '0;
         satSt_d = 1'b0;
         errSt_d = 1'b0;
      end else if (beatFire) begin
         acc_d   = sum;
         idx_d   = idx_q + ADDR_W'(1);
         satSt_d = satSt_q | mulSat | addSat;
         errSt_d = errSt_q | (x_last != lastIdx);
         if (frameEnd) begin
            yData_d = sum;
            ySat_d  = satSt_d;
            yErr_d  = errSt_d;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q   <= '0;
         idx_q   <= '0;
         satSt_q <= 1'b0;
         errSt_q <= 1'b0;
         yData_q <= '0;
         ySat_q  <= 1'b0;
         yErr_q  <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         satSt_q <= satSt_d;
         errSt_q <= errSt_d;
         yData_q <= yData_d;
         ySat_q  <= ySat_d;
         yErr_q  <= yErr_d;
      end
   end

   // Coefficients are only writable while idle so a frame never sees a half-updated set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_FEAT; i++) w_q[i] <= '0;
         bias_q <= '0;
      end else if ((state_q == IDLE) && cfg_we) begin
         for (int i = 0; i < N_FEAT; i++)
            if (cfg_addr == ADDR_W'(i)) w_q[i] <= cfg_wdata;
         if (cfg_addr == ADDR_W'(N_FEAT)) bias_q <= cfg_wdata;
      end
   end
endmodule

// File: tb/tb_lr_dot_seq.sv
// Directed bench for lr_dot_seq: hand-computed Q16.16 predictions, framing errors,
// saturation, backpressure, abort and asynchronous reset.

module tb_lr_dot_seq;
   localparam int WIDTH = 32, FRACTION = 16, N_FEAT = 8, ADDR_W = 4;

   logic              clk = 1'b0;
   logic              rst_n, en, cfg_we, x_valid, x_last, y_ready;
   logic [ADDR_W-1:0] cfg_addr;
   logic [WIDTH-1:0]  cfg_wdata, x_data;
   logic              x_ready, y_valid, y_sat, y_err, busy;
   logic [WIDTH-1:0]  y_data;

   int compared = 0, mismatched = 0;
   logic [31:0] xv [8];

   always #5 clk = ~clk;

   lr_dot_seq #(.WIDTH(WIDTH), .FRACTION(FRACTION), .N_FEAT(N_FEAT), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_wdata(cfg_wdata), .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
      .x_last(x_last), .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data),
      .y_sat(y_sat), .y_err(y_err), .busy(busy)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // One feature beat, driven at a falling edge and held until accepted.
   task automatic applyStimulus(input logic [31:0] d, input logic last);
      int n;
      x_valid = 1'b1; x_data = d; x_last = last; n = 0;
      while (x_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) checkOutput("xReadyTimeout", {31'b0, x_ready}, 32'd1);
      @(negedge clk);
      x_valid = 1'b0; x_last = 1'b0;
   endtask

   task automatic cfgWrite(input logic [ADDR_W-1:0] a, input logic [31:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic fillX(input logic [31:0] v);
      for (int i = 0; i < 8; i++) xv[i] = v;
   endtask

   task automatic runFrame(input int nBeats, input int lastAt, input string tag);
      for (int i = 0; i < nBeats; i++) applyStimulus(xv[i], (i == lastAt));
      checkOutput({tag, "_latency"}, {31'b0, y_valid}, 32'd1);
   endtask

   task automatic collectResult(input logic [31:0] expData, input logic expSat, input logic expErr,
                                input string tag);
      int n;
      n = 0;
      while (y_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      checkOutput({tag, "_valid"}, {31'b0, y_valid}, 32'd1);
      checkOutput({tag, "_data"}, y_data, expData);
      checkOutput({tag, "_sat"}, {31'b0, y_sat}, {31'b0, expSat});
      checkOutput({tag, "_err"}, {31'b0, y_err}, {31'b0, expErr});
      y_ready = 1'b1;
      @(negedge clk);
      y_ready = 1'b0;
      checkOutput({tag, "_validDrop"}, {31'b0, y_valid}, 32'd0);
   endtask

   task automatic gotoIdle();
      en = 1'b0;
      @(negedge clk);
      checkOutput("idleBusy", {31'b0, busy}, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
      x_valid = 1'b0; x_data = '0; x_last = 1'b0; y_ready = 1'b0;
      @(negedge clk); @(negedge clk);
      checkOutput("rstValid", {31'b0, y_valid}, 32'd0);
      checkOutput("rstBusy", {31'b0, busy}, 32'd0);
      checkOutput("rstXReady", {31'b0, x_ready}, 32'd0);
      checkOutput("rstData", y_data, 32'd0);
      checkOutput("rstSat", {31'b0, y_sat}, 32'd0);
      checkOutput("rstErr", {31'b0, y_err}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] test 1: unit weights, x=1..8, bias 0.5");
      for (int i = 0; i < 8; i++) cfgWrite(ADDR_W'(i), 32'h0001_0000);
      cfgWrite(4'd8, 32'h0000_8000);
      cfgWrite(4'd9, 32'h1234_5678);
      cfgWrite(4'd15, 32'h7654_3210);
      en = 1'b1;
      @(negedge clk);
      checkOutput("t1Busy", {31'b0, busy}, 32'd1);
      checkOutput("t1XReady", {31'b0, x_ready}, 32'd1);
      for (int i = 0; i < 8; i++) xv[i] = 32'((i + 1) * 65536);
      runFrame(8, 7, "t1");
      collectResult(32'h0024_8000, 1'b0, 1'b0, "t1");

      $display("[TB] test 2: product saturation");
      gotoIdle();
      cfgWrite(4'd0, 32'h7FFF_0000);
      en = 1'b1;
      @(negedge clk);
      fillX(32'h0);
      xv[0] = 32'h0002_0000;
      runFrame(8, 7, "t2");
      collectResult(32'h7FFF_FFFF, 1'b1, 1'b0, "t2");

      $display("[TB] test 3: framing errors");
      gotoIdle();
      cfgWrite(4'd0, 32'h0002_0000);
      cfgWrite(4'd1, 32'h0003_0000);
      cfgWrite(4'd2, 32'hFFFF_0000);
      en = 1'b1;
      @(negedge clk);
      xv[0] = 32'h0001_0000; xv[1] = 32'h0000_8000; xv[2] = 32'h0002_0000;
      runFrame(3, 2, "t3early");
      collectResult(32'h0002_0000, 1'b0, 1'b1, "t3early");
      fillX(32'h0001_0000);
      runFrame(8, 7, "t3good");
      collectResult(32'h0009_8000, 1'b0, 1'b0, "t3good");
      runFrame(8, -1, "t3noLast");
      collectResult(32'h0009_8000, 1'b0, 1'b1, "t3noLast");

      $display("[TB] test 4: output backpressure");
      runFrame(8, 7, "t4");
      for (int k = 0; k < 5; k++) begin
         checkOutput("t4HoldValid", {31'b0, y_valid}, 32'd1);
         checkOutput("t4HoldXReady", {31'b0, x_ready}, 32'd0);
         checkOutput("t4HoldData", y_data, 32'h0009_8000);
         @(negedge clk);
      end
      collectResult(32'h0009_8000, 1'b0, 1'b0, "t4");
      fillX(32'h0);
      runFrame(8, 7, "t4next");
      collectResult(32'h0000_8000, 1'b0, 1'b0, "t4next");

      $display("[TB] test 5: abort and config gating");
      for (int i = 0; i < 4; i++) applyStimulus(32'h0001_0000, 1'b0);
      en = 1'b0; cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = 32'h0005_0000;
      @(negedge clk);
      cfg_we = 1'b0;
      checkOutput("t5AbortBusy", {31'b0, busy}, 32'd0);
      checkOutput("t5AbortXReady", {31'b0, x_ready}, 32'd0);
      for (int k = 0; k < 3; k++) begin
         checkOutput("t5NoValid", {31'b0, y_valid}, 32'd0);
         @(negedge clk);
      end
      en = 1'b1;
      @(negedge clk);
      fillX(32'h0);
      xv[0] = 32'h0001_0000;
      runFrame(8, 7, "t5ignored");
      collectResult(32'h0002_8000, 1'b0, 1'b0, "t5ignored");
      gotoIdle();
      cfgWrite(4'd0, 32'h0005_0000);
      cfgWrite(4'd1, 32'h0000_8000);
      en = 1'b1;
      @(negedge clk);
      xv[1] = 32'h0000_0003;
      runFrame(8, 7, "t5taken");
      collectResult(32'h0005_8002, 1'b0, 1'b0, "t5taken");

      $display("[TB] test 6: asynchronous reset in OUT");
      fillX(32'h0);
      runFrame(8, 7, "t6");
      #2 rst_n = 1'b0;
      #1;
      checkOutput("t6RstValid", {31'b0, y_valid}, 32'd0);
      checkOutput("t6RstBusy", {31'b0, busy}, 32'd0);
      checkOutput("t6RstXReady", {31'b0, x_ready}, 32'd0);
      checkOutput("t6RstData", y_data, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      fillX(32'h0001_0000);
      runFrame(8, 7, "t6post");
      collectResult(32'h0000_0000, 1'b0, 1'b0, "t6post");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
